ubmpadd_sched: RTL and testbench
================================

# ubmpadd_sched

Scheduler that shares one 25-bit carry-skip adder core between two requesters and sequences multi-limb (multi-precision) additions through it, one 25-bit limb per cycle. The carry between limbs is held in a register. A requester owns the adder for a whole burst (first limb to last limb), and a round-robin arbiter chooses the owner between bursts. Results leave through a single registered output stage with valid/ready backpressure. The block sits between wide-operand clients and the existing `UBPriVCSkA_24_0` datapath.

## Interface
- `LIMB_W`, 25: limb width; fixed to the adder width, not overridable.
- `MAX_LIMBS`, 8: maximum limbs per burst; range 1..256.
- `CNT_W`, `$clog2(MAX_LIMBS+1)`: burst counter width.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `REQ_VALID` in 2: per-requester beat valid; index r = 0, 1.
- `REQ_READY` out 2: per-requester beat accepted when VALID & READY.
- `REQ_FIRST` in 2: beat is the first limb of a burst.
- `REQ_LAST` in 2: beat is the last limb of a burst.
- `REQ_CIN` in 2: carry-in, sampled only on a FIRST beat.
- `REQ_X0`, `REQ_Y0` in LIMB_W: requester 0 operand limbs.
- `REQ_X1`, `REQ_Y1` in LIMB_W: requester 1 operand limbs.
- `RES_VALID` out 1: result beat valid.
- `RES_READY` in 1: downstream accepts the result beat.
- `RES_S` out LIMB_W: sum limb.
- `RES_CO` out 1: carry-out of the limb; meaningful on the LAST beat.
- `RES_LAST` out 1: final limb of a burst.
- `RES_ID` out 1: owning requester.
- `ERR` out 1: one-cycle pulse, aligned with the result, on a protocol violation.

## Operation
- States:
  - IDLE: no owner.
  - BURST: locked to `own`.
- Output slot free when `~RES_VALID | RES_READY`.
- In IDLE, only beats with FIRST=1 are eligible.
  - One eligible requester: it is granted.
  - Both eligible: the requester at round-robin pointer `ptr` is granted.
- In BURST, only requester `own` is eligible, with or without FIRST. The other requester's READY is 0.
- `REQ_READY[r]` = eligible(r) & granted(r) & slot free.
- Accepted beat:
  - adder inputs: X, Y of the granted requester; Cin = FIRST ? REQ_CIN : `carry_q`.
  - `carry_q` ← adder S[25].
  - output register ← {S[24:0], S[25], last_eff, r}.
  - `cnt` ← FIRST ? 1 : cnt+1.
- `last_eff` = REQ_LAST | (cnt_next == MAX_LIMBS).
  - Forced termination (cnt reaches MAX_LIMBS without LAST) sets RES_LAST=1 and pulses ERR.
- Transitions:
  - IDLE→BURST on an accepted FIRST beat with last_eff=0; `own` ← r.
  - Any accepted beat with last_eff=1 → IDLE; `ptr` ← ~r.
  - A FIRST&LAST beat stays in / returns to IDLE; `ptr` is updated.
- FIRST=1 from the owner mid-burst: restarts the chain (Cin=REQ_CIN, cnt=1) and pulses ERR.
- REQ_VALID without FIRST in IDLE: never accepted; READY=0, no ERR.

## Timing
- Latency 1: a beat accepted at edge k is visible on RES_* immediately after edge k.
- Throughput: one limb per cycle while RES_READY=1.
- RES_* hold stable while RES_VALID & ~RES_READY. No beat is dropped or duplicated.
- Grant decision is combinational from VALID, FIRST, state, `ptr` and the slot-free term. No idle cycle between back-to-back bursts.
- Reset values:
  - outputs: RES_VALID, RES_S, RES_CO, RES_LAST, RES_ID, ERR, REQ_READY all 0.
  - internal: state IDLE, `ptr`=0, `carry_q`=0, `cnt`=0.
- Reset mid-burst: the burst is abandoned with no result and the output register is cleared asynchronously. Requesters must restart with FIRST.

## Structure
- Package `ubmpadd_pkg`:
  - `LIMB_W`=25
  - state enum {IDLE, BURST}
  - result struct {s, co, last, id}
- One sub-module: `UBPriVCSkA_24_0` (S[25:0], X, Y, Cin), instanced once with its inputs muxed by the grant.
- Arbiter, counter and output register are inline.

## Test plan
- Single-limb carry: r0 FIRST=LAST=1, X=0x1FFFFFF, Y=0x0000001, CIN=0 → next cycle RES_S=0, RES_CO=1, RES_LAST=1, RES_ID=0.
- 3-limb chain: r1 limbs X=0x1FFFFFF each, Y=0, CIN=1 → RES_S=0,0,0 on consecutive cycles; RES_CO=1 on the LAST beat.
- Tie after reset: both send FIRST&LAST with X=5, Y=3 → r0 result 8 first, r1 result 8 the next cycle; a second tie is granted to r0 again (`ptr` back to 0 after r1).
- Backpressure: 4-limb burst with RES_READY=0 for 3 cycles after beat 2 → REQ_READY=0 and RES_* frozen for those cycles; all 4 sums delivered in order.
- Overlong burst: MAX_LIMBS=8, 9 beats with LAST=0 → beat 8 gives RES_LAST=1 and ERR=1; the 9th beat (no FIRST) is not accepted.
- Reset mid-burst: RST_N low after limb 2 of 4 → RES_VALID=0 at once; after release, an r1 FIRST&LAST beat X=1, Y=1 gives RES_S=2.

Source files
------------

// File: rtl/ubmpadd_pkg.sv
// Shared types for the multi-limb adder scheduler: limb width, FSM states and
// the registered result beat.
package ubmpadd_pkg;
  localparam int LIMB_W = 25;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic [LIMB_W-1:0] s;
    logic              co;
    logic              last;
    logic              id;
  } res_t;
endpackage

// File: rtl/ubmpadd_sched_if.sv
// Request/result bundle between the wide-operand clients and the scheduler.
interface ubmpadd_sched_if
  import ubmpadd_pkg::*;
();
  logic [1:0]        REQ_VALID;
  logic [1:0]        REQ_READY;
  logic [1:0]        REQ_FIRST;
  logic [1:0]        REQ_LAST;
  logic [1:0]        REQ_CIN;
  logic [LIMB_W-1:0] REQ_X0;
  logic [LIMB_W-1:0] REQ_Y0;
  logic [LIMB_W-1:0] REQ_X1;
  logic [LIMB_W-1:0] REQ_Y1;
  logic              RES_VALID;
  logic              RES_READY;
  logic [LIMB_W-1:0] RES_S;
  logic              RES_CO;
  logic              RES_LAST;
  logic              RES_ID;
  logic              ERR;

  modport master (
    output REQ_VALID, REQ_FIRST, REQ_LAST, REQ_CIN,
    output REQ_X0, REQ_Y0, REQ_X1, REQ_Y1, RES_READY,
    input  REQ_READY, RES_VALID, RES_S, RES_CO, RES_LAST, RES_ID, ERR
  );

  modport slave (
    input  REQ_VALID, REQ_FIRST, REQ_LAST, REQ_CIN,
    input  REQ_X0, REQ_Y0, REQ_X1, REQ_Y1, RES_READY,
    output REQ_READY, RES_VALID, RES_S, RES_CO, RES_LAST, RES_ID, ERR
  );
endinterface

// File: rtl/UBPriVCSkA_24_0.sv
// 25-bit unsigned carry-skip adder: five 5-bit ripple blocks, each bypassed by
// its incoming carry when every bit of the block propagates.
module UBPriVCSkA_24_0 (
  output logic [25:0] S,
  input  logic [24:0] X,
  input  logic [24:0] Y,
  input  logic        Cin
);
  logic [24:0] p;
  logic [24:0] g;
  logic [24:0] rc;
  logic [5:0]  bc;
  logic        ro;

  always_comb begin
    p  = X ^ Y;
    g  = X & Y;
    rc = '0;
    bc = '0;
    ro = 1'b0;
    bc[0] = Cin;
    for (int b = 0; b < 5; b++) begin
      rc[b*5] = bc[b];
      for (int i = 0; i < 4; i++) begin
        rc[b*5+i+1] = g[b*5+i] | (p[b*5+i] & rc[b*5+i]);
      end
      ro = g[b*5+4] | (p[b*5+4] & rc[b*5+4]);
      bc[b+1] = (&p[b*5 +: 5]) ? bc[b] : ro;
    end
    S = {bc[5], p ^ rc};
  end
endmodule

// File: rtl/ubmpadd_sched.sv
// Two-requester burst scheduler sharing one carry-skip adder; one limb per
// cycle, carry chained between limbs, round-robin ownership between bursts.
module ubmpadd_sched
  import ubmpadd_pkg::*;
#(
  parameter int MAX_LIMBS = 8,
  localparam int CNT_W = $clog2(MAX_LIMBS + 1)
) (
  input logic            CLK,
  input logic            RST_N,
  ubmpadd_sched_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LIMBS);

  state_t            state_q, state_d;
  logic              own_q, own_d;
  logic              ptr_q, ptr_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;

  res_t              res_p1;
  logic              vld_p1;
  logic              err_p1;

  logic              slot_free;
  logic [1:0]        elig;
  logic [1:0]        ready;
  logic              gnt;
  logic              acc;
  logic              first_g, last_g, cin_g;
  logic [LIMB_W-1:0] x_g, y_g;
  logic [LIMB_W:0]   sum;
  logic              last_eff;
  logic              err_now;

  UBPriVCSkA_24_0 u_add (
    .S   (sum),
    .X   (x_g),
    .Y   (y_g),
    .Cin (cin_g)
  );

  always_comb begin
    slot_free = ~vld_p1 | bus.RES_READY;
    elig      = '0;
    gnt       = ptr_q;
    if (state_q == IDLE) begin
      elig = bus.REQ_VALID & bus.REQ_FIRST;
      case (elig)
        2'b01:   gnt = 1'b0;
        2'b10:   gnt = 1'b1;
        default: gnt = ptr_q;
      endcase
    end else begin
      elig[own_q] = bus.REQ_VALID[own_q];
      gnt         = own_q;
    end
    // READY is forced low while reset is asserted so nothing is handed over.
    ready      = '0;
    ready[gnt] = elig[gnt] & slot_free & RST_N;
    acc        = |ready;

    first_g  = bus.REQ_FIRST[gnt];
    last_g   = bus.REQ_LAST[gnt];
    x_g      = gnt ? bus.REQ_X1 : bus.REQ_X0;
    y_g      = gnt ? bus.REQ_Y1 : bus.REQ_Y0;
    cin_g    = first_g ? bus.REQ_CIN[gnt] : carry_q;
    cnt_nxt  = first_g ? CNT_W'(1) : cnt_q + CNT_W'(1);
    last_eff = last_g | (cnt_nxt == CNT_MAX);
    err_now  = (~last_g & (cnt_nxt == CNT_MAX)) | (first_g & (state_q == BURST));

    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (acc) begin
      carry_d = sum[LIMB_W];
      cnt_d   = cnt_nxt;
      if (last_eff) begin
        state_d = IDLE;
        ptr_d   = ~gnt;
      end else begin
        state_d = BURST;
        own_d   = gnt;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      ptr_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p1: registered result beat, held until the downstream takes it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_p1 <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      if (acc) begin
        res_p1 <= '{s: sum[LIMB_W-1:0], co: sum[LIMB_W], last: last_eff, id: gnt};
        vld_p1 <= 1'b1;
      end else if (bus.RES_READY) begin
        vld_p1 <= 1'b0;
      end
      err_p1 <= acc & err_now;
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.RES_VALID = vld_p1;
  assign bus.RES_S     = res_p1.s;
  assign bus.RES_CO    = res_p1.co;
  assign bus.RES_LAST  = res_p1.last;
  assign bus.RES_ID    = res_p1.id;
  assign bus.ERR       = err_p1;
endmodule

// File: tb/tb_ubmpadd_sched.sv
// Scoreboard bench for ubmpadd_sched: accepted beats are modelled and queued,
// result beats are popped and compared as the DUT hands them downstream.
module tb_ubmpadd_sched;
  import ubmpadd_pkg::*;

  typedef struct {
    logic [24:0] s;
    logic        co;
    logic        last;
    logic        id;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   m_cnt = 0;
  logic m_carry = 1'b0;
  logic m_busy = 1'b0;

  ubmpadd_sched_if bus ();

  ubmpadd_sched #(.MAX_LIMBS(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input int r, input logic first, input logic last, input logic cin,
                      input logic [24:0] x, input logic [24:0] y);
    int k;
    bus.REQ_VALID[r] = 1'b1;
    bus.REQ_FIRST[r] = first;
    bus.REQ_LAST[r]  = last;
    bus.REQ_CIN[r]   = cin;
    if (r == 0) begin bus.REQ_X0 = x; bus.REQ_Y0 = y; end
    else        begin bus.REQ_X1 = x; bus.REQ_Y1 = y; end
    for (k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.REQ_READY[r]) break;
    end
    if (k == 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    bus.REQ_VALID[r] = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Monitor: pop/compare delivered results, then model and queue accepted beats.
  initial begin
    exp_t        e;
    logic [24:0] x, y;
    logic        cf, le;
    logic [25:0] sm;
    int          nc;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        sb.delete();
        m_busy = 1'b0; m_carry = 1'b0; m_cnt = 0;
      end else begin
        if (bus.RES_VALID && bus.RES_READY) begin
          if (sb.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("res_s",    32'(bus.RES_S),    32'(e.s));
            chk("res_co",   32'(bus.RES_CO),   32'(e.co));
            chk("res_last", 32'(bus.RES_LAST), 32'(e.last));
            chk("res_id",   32'(bus.RES_ID),   32'(e.id));
            chk("res_err",  32'(bus.ERR),      32'(e.err));
          end
        end
        for (int r = 0; r < 2; r++) begin
          if (bus.REQ_VALID[r] && bus.REQ_READY[r]) begin
            x  = (r == 0) ? bus.REQ_X0 : bus.REQ_X1;
            y  = (r == 0) ? bus.REQ_Y0 : bus.REQ_Y1;
            cf = bus.REQ_FIRST[r] ? bus.REQ_CIN[r] : m_carry;
            sm = {1'b0, x} + {1'b0, y} + {25'd0, cf};
            nc = bus.REQ_FIRST[r] ? 1 : m_cnt + 1;
            le = bus.REQ_LAST[r] | (nc == 8);
            e.s    = sm[24:0];
            e.co   = sm[25];
            e.last = le;
            e.id   = (r == 1);
            e.err  = ((nc == 8) & ~bus.REQ_LAST[r]) | (bus.REQ_FIRST[r] & m_busy);
            sb.push_back(e);
            m_carry = sm[25];
            m_cnt   = nc;
            m_busy  = ~le;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RST_N         = 1'b0;
    bus.RES_READY = 1'b1;
    bus.REQ_VALID = 2'b11;
    bus.REQ_FIRST = 2'b11;
    bus.REQ_LAST  = 2'b11;
    bus.REQ_CIN   = 2'b00;
    bus.REQ_X0 = 25'd1; bus.REQ_Y0 = 25'd1;
    bus.REQ_X1 = 25'd1; bus.REQ_Y1 = 25'd1;
    #2;
    chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
    chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
    chk("rst_res_s",     32'(bus.RES_S),     32'd0);
    chk("rst_res_co",    32'(bus.RES_CO),    32'd0);
    chk("rst_res_last",  32'(bus.RES_LAST),  32'd0);
    chk("rst_res_id",    32'(bus.RES_ID),    32'd0);
    chk("rst_err",       32'(bus.ERR),       32'd0);
    bus.REQ_VALID = 2'b00;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Single-limb carry out of the top bit.
    send(0, 1'b1, 1'b1, 1'b0, 25'h1FFFFFF, 25'h0000001);
    chk("lat1_valid", 32'(bus.RES_VALID), 32'd1);
    chk("lat1_s",     32'(bus.RES_S),     32'd0);

    // Three-limb carry chain on requester 1.
    send(1, 1'b1, 1'b0, 1'b1, 25'h1FFFFFF, 25'h0);
    send(1, 1'b0, 1'b0, 1'b0, 25'h1FFFFFF, 25'h0);
    send(1, 1'b0, 1'b1, 1'b0, 25'h1FFFFFF, 25'h0);

    // Round-robin ties after reset.
    do_reset();
    bus.REQ_FIRST = 2'b11; bus.REQ_LAST = 2'b11; bus.REQ_CIN = 2'b00;
    bus.REQ_X0 = 25'd5; bus.REQ_Y0 = 25'd3;
    bus.REQ_X1 = 25'd5; bus.REQ_Y1 = 25'd3;
    for (int t = 0; t < 2; t++) begin
      bus.REQ_VALID = 2'b11;
      @(negedge CLK);
      chk("tie_rdy_r0", 32'(bus.REQ_READY), 32'd1);
      @(posedge CLK); #1;
      bus.REQ_VALID[0] = 1'b0;
      @(negedge CLK);
      chk("tie_rdy_r1", 32'(bus.REQ_READY), 32'd2);
      @(posedge CLK); #1;
      bus.REQ_VALID = 2'b00;
    end

    // Backpressure in the middle of a 4-limb burst.
    send(0, 1'b1, 1'b0, 1'b0, 25'h1A5A5A5, 25'h0C3C3C3);
    send(0, 1'b0, 1'b0, 1'b0, 25'h0123456, 25'h1F0F0F0);
    bus.RES_READY = 1'b0;
    bus.REQ_VALID[0] = 1'b1; bus.REQ_FIRST[0] = 1'b0; bus.REQ_LAST[0] = 1'b0;
    bus.REQ_X0 = 25'h1555555; bus.REQ_Y0 = 25'h0AAAAAB;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("bp_req_ready", 32'(bus.REQ_READY), 32'd0);
      chk("bp_res_valid", 32'(bus.RES_VALID), 32'd1);
      chk("bp_hold_s",    32'(bus.RES_S),     (sb.size() > 0) ? 32'(sb[0].s) : 32'hFFFFFFFF);
      @(posedge CLK); #1;
    end
    bus.RES_READY = 1'b1;
    send(0, 1'b0, 1'b0, 1'b0, 25'h1555555, 25'h0AAAAAB);
    send(0, 1'b0, 1'b1, 1'b0, 25'h0000007, 25'h0000009);

    // Overlong burst: forced end at limb 8, ninth limb refused.
    send(1, 1'b1, 1'b0, 1'b0, 25'h1000000, 25'h1000000);
    for (int b = 2; b <= 8; b++) send(1, 1'b0, 1'b0, 1'b0, 25'(b * 25'h0111111), 25'h1800000);
    bus.REQ_VALID[1] = 1'b1; bus.REQ_FIRST[1] = 1'b0; bus.REQ_LAST[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("long_no_accept", 32'(bus.REQ_READY), 32'd0);
      @(posedge CLK); #1;
    end
    bus.REQ_VALID[1] = 1'b0;

    // Owner restarts with FIRST inside a burst.
    send(0, 1'b1, 1'b0, 1'b0, 25'h1FFFFFF, 25'h1FFFFFF);
    send(0, 1'b1, 1'b1, 1'b1, 25'h0000010, 25'h0000020);

    // Reset in the middle of a 4-limb burst.
    send(0, 1'b1, 1'b0, 1'b0, 25'h0000100, 25'h0000200);
    send(0, 1'b0, 1'b0, 1'b0, 25'h0000300, 25'h0000400);
    do_reset();
    chk("rst_mid_s", 32'(bus.RES_S), 32'd0);
    send(1, 1'b1, 1'b1, 1'b0, 25'd1, 25'd1);

    repeat (3) @(posedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
